uplink_elink_aligner: RTL

UPLINK_ELINK_ALIGNER -- requirements
Module: uplink_elink_aligner

---
 rtl/lpgbt_uplink_pkg.sv | 7 +
 rtl/elink_bit_rotator.sv | 12 +
 rtl/uplink_elink_aligner.sv | 107 ++++++++++
 3 files changed

// File: rtl/lpgbt_uplink_pkg.sv
// lpgbt_uplink_pkg: shared widths and FSM states for the lpGBT uplink elink aligner
package lpgbt_uplink_pkg;
  localparam int GROUP_W = 32;
  localparam int FRAME_W = 234;
  localparam int ROT_W = 5;
  typedef enum logic [1:0] {IDLE, SEARCH, CONFIRM, LOCKED} state_t;
endpackage

// File: rtl/elink_bit_rotator.sv
// elink_bit_rotator: selects a W-bit slice of a 2W-bit window at a bit offset
module elink_bit_rotator
  import lpgbt_uplink_pkg::*;
#(
  parameter int W = GROUP_W
) (
  input  logic [2*W-1:0]   window,
  input  logic [ROT_W-1:0] rot,
  output logic [W-1:0]     slice
);
  assign slice = window[rot +: W];
endmodule

// File: rtl/uplink_elink_aligner.sv
// uplink_elink_aligner: bit-aligns one elink group of the lpGBT uplink frame to a sync word
module uplink_elink_aligner
  import lpgbt_uplink_pkg::FRAME_W, lpgbt_uplink_pkg::ROT_W, lpgbt_uplink_pkg::state_t,
         lpgbt_uplink_pkg::IDLE, lpgbt_uplink_pkg::SEARCH, lpgbt_uplink_pkg::CONFIRM,
         lpgbt_uplink_pkg::LOCKED;
#(
  parameter int GROUP_W  = lpgbt_uplink_pkg::GROUP_W,
  parameter int N_GROUPS = 7,
  parameter int LOCK_CNT = 8
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic [FRAME_W-1:0] uplinkUserData_i,
  input  logic               uplinkValid_i,
  input  logic               uplinkrdy_i,
  input  logic               align_en_i,
  input  logic [2:0]         group_sel_i,
  input  logic [GROUP_W-1:0] sync_word_i,
  input  logic               relock_i,
  output logic [GROUP_W-1:0] word_o,
  output logic               word_valid_o,
  output logic               locked_o,
  output logic [ROT_W-1:0]   rot_o,
  output logic [15:0]        sweep_cnt_o
);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  state_t state, nxt;
  logic [ROT_W-1:0] rot, rot_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0] sweep, sweep_nxt;
  logic [2:0] grp;
  logic [GROUP_W-1:0] sync, prev, cur, slice;
  logic [8*GROUP_W-1:0] frame_ext;
  logic force_idle, take, start, hit;
  assign frame_ext = {{(8*GROUP_W-FRAME_W){1'b0}}, uplinkUserData_i};
  assign cur = frame_ext[int'(grp)*GROUP_W +: GROUP_W];
  assign force_idle = !align_en_i || !uplinkrdy_i;
  // a forced return to IDLE also discards the frame of that cycle
  assign take = uplinkValid_i && !force_idle;
  assign start = state == IDLE && !force_idle && int'(group_sel_i) < N_GROUPS;
  assign hit = slice == sync;
  assign rot_o = rot;
  assign sweep_cnt_o = sweep;
  elink_bit_rotator #(.W(GROUP_W)) u_rot (
    .window({cur, prev}),
    .rot   (rot),
    .slice (slice)
  );
  always_comb begin
    nxt = state;
    rot_nxt = rot;
    cnt_nxt = cnt;
    sweep_nxt = sweep;
    if (force_idle) nxt = IDLE;
    else if (start) begin
      nxt = SEARCH;
      rot_nxt = '0;
      cnt_nxt = '0;
      sweep_nxt = '0;
    end else if (state == LOCKED && relock_i) begin
      nxt = SEARCH;
      rot_nxt = '0;
      cnt_nxt = '0;
    end else if (uplinkValid_i && state == SEARCH) begin
      if (hit) begin
        nxt = LOCK_CNT <= 1 ? LOCKED : CONFIRM;
        cnt_nxt = CNT_W'(1);
      end else begin
        rot_nxt = rot + 1'b1;
        sweep_nxt = (&rot && sweep != 16'hFFFF) ? sweep + 1'b1 : sweep;
      end
    end else if (uplinkValid_i && state == CONFIRM) begin
      nxt = hit ? (int'(cnt) + 1 >= LOCK_CNT ? LOCKED : CONFIRM) : SEARCH;
      cnt_nxt = hit ? cnt + 1'b1 : '0;
      rot_nxt = hit ? rot : rot + 1'b1;
    end
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state <= IDLE;
      rot <= '0;
      cnt <= '0;
      sweep <= '0;
      grp <= '0;
      sync <= '0;
      prev <= '0;
      word_o <= '0;
      word_valid_o <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      state <= nxt;
      rot <= rot_nxt;
      cnt <= cnt_nxt;
      sweep <= sweep_nxt;
      locked_o <= nxt == LOCKED;
      word_valid_o <= take && state == LOCKED;
      if (start) begin
        grp <= group_sel_i;
        sync <= sync_word_i;
      end
      if (take) begin
        prev <= cur;
        word_o <= slice;
      end
    end
  end
endmodule
